// File: rtl/mudi_seq.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at launch into a shadow register and committed after a fixed latency.
module mudi_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [2:0] MUDI_MULT  = 3'd0;
    localparam logic [2:0] MUDI_MULTU = 3'd1;
    localparam logic [2:0] MUDI_DIV   = 3'd2;
    localparam logic [2:0] MUDI_DIVU  = 3'd3;
    localparam logic [2:0] MUDI_MFHI  = 3'd4;
    localparam logic [2:0] MUDI_MFLO  = 3'd5;
    localparam logic [2:0] MUDI_MTHI  = 3'd6;
    localparam logic [2:0] MUDI_MTLO  = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  count;
    logic [63:0] shadow;
    logic        div_zero;
    logic        launch;
    logic        is_mul;
    logic        is_div;
    logic        commit;
    logic [63:0] product;
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign launch = (state == IDLE) && start && !flush;
    assign is_mul = (op == MUDI_MULT) || (op == MUDI_MULTU);
    assign is_div = (op == MUDI_DIV) || (op == MUDI_DIVU);
    assign commit = (state != IDLE) && (count == 4'd1);

    // Sign extension followed by a modulo-2^64 multiply yields the two's complement product.
    assign product = (op == MUDI_MULT) ? ({{32{a[31]}}, a} * {{32{b[31]}}, b})
                                       : ({32'd0, a} * {32'd0, b});

    always_comb begin
        div_q = '0;
        div_r = '0;
        if (b != '0) begin
            if (op == MUDI_DIV) begin
                div_q = $signed(a) / $signed(b);
                div_r = $signed(a) % $signed(b);
            end else begin
                div_q = a / b;
                div_r = a % b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            shadow   <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= next_state;
            if (launch && is_mul) begin
                shadow   <= product;
                div_zero <= 1'b0;
                count    <= 4'd5;
            end else if (launch && is_div) begin
                shadow   <= {div_r, div_q};
                div_zero <= (b == '0);
                count    <= 4'd10;
            end else if (state != IDLE) begin
                count <= count - 4'd1;
            end
            if (commit && !div_zero) begin
                hi <= shadow[63:32];
                lo <= shadow[31:0];
            end
            // start wins over we when both are raised together.
            if (state == IDLE && we && !flush && !start) begin
                if (op == MUDI_MTHI) hi <= a;
                if (op == MUDI_MTLO) lo <= a;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch && is_mul)      next_state = MUL;
                else if (launch && is_div) next_state = DIV;
            end
            MUL, DIV: begin
                if (count == 4'd1) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = busy || (start && !flush);
        rdata = '0;
        if (op == MUDI_MFHI)      rdata = hi;
        else if (op == MUDI_MFLO) rdata = lo;
    end

endmodule

// File: tb/tb_mudi_seq.sv
// Directed testbench for mudi_seq: multiply/divide latency and results, moves, flush and reset abort.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_mudi_seq;

    localparam logic [2:0] MUDI_MULT  = 3'd0;
    localparam logic [2:0] MUDI_MULTU = 3'd1;
    localparam logic [2:0] MUDI_DIV   = 3'd2;
    localparam logic [2:0] MUDI_DIVU  = 3'd3;
    localparam logic [2:0] MUDI_MFHI  = 3'd4;
    localparam logic [2:0] MUDI_MFLO  = 3'd5;
    localparam logic [2:0] MUDI_MTHI  = 3'd6;
    localparam logic [2:0] MUDI_MTLO  = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    mudi_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .we    (we),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; we = 1'b0; flush = 1'b0;
        op = MUDI_MFLO; a = '0; b = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: busy=%b stall=%b, expected 0 0", busy, stall);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_hilo: hi=%h lo=%h, expected 0 0", hi, lo);
        end
    endtask

    task automatic test_mult();
        op = MUDI_MULT; a = 32'hFFFFFFFF; b = 32'h00000002; start = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mult_stall: stall=%b, expected 1", stall);
        end
        tick();
        start = 1'b0; op = MUDI_MFHI;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (busy !== 1'b1 || rdata !== 32'h0) begin
                errors++;
                $display("[TB] FAIL mult_busy%0d: busy=%b rdata=%h, expected 1 00000000", i, busy, rdata);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL mult_result: busy=%b hi=%h lo=%h, expected 0 ffffffff fffffffe", busy, hi, lo);
        end
    endtask

    task automatic test_multu_flush_inflight();
        op = MUDI_MULTU; a = 32'hFFFFFFFF; b = 32'h00000002; start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL multu_busy%0d: busy=%b, expected 1", i, busy);
            end
            tick();
        end
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL multu_result: busy=%b hi=%h lo=%h, expected 0 00000001 fffffffe", busy, hi, lo);
        end
    endtask

    task automatic test_div();
        op = MUDI_DIV; a = 32'hFFFFFFF9; b = 32'h00000002; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== 32'h00000001) begin
                errors++;
                $display("[TB] FAIL div_busy%0d: busy=%b hi=%h, expected 1 00000001", i, busy, hi);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL div_result: busy=%b hi=%h lo=%h, expected 0 ffffffff fffffffd", busy, hi, lo);
        end
    endtask

    task automatic test_div_zero();
        op = MUDI_DIVU; a = 32'h00000064; b = 32'h00000000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL divz_busy%0d: busy=%b, expected 1", i, busy);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL divz_result: busy=%b hi=%h lo=%h, expected 0 ffffffff fffffffd", busy, hi, lo);
        end
    endtask

    task automatic test_moves();
        op = MUDI_MTHI; a = 32'h12345678; we = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mthi_stall: stall=%b, expected 0", stall);
        end
        tick();
        we = 1'b0; op = MUDI_MFHI;
        #1;
        checks++;
        if (hi !== 32'h12345678 || busy !== 1'b0 || rdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL mthi_result: hi=%h busy=%b rdata=%h, expected 12345678 0 12345678", hi, busy, rdata);
        end
        op = MUDI_MTLO; a = 32'hCAFEF00D; we = 1'b1;
        tick();
        we = 1'b0; op = MUDI_MFLO;
        #1;
        checks++;
        if (lo !== 32'hCAFEF00D || rdata !== 32'hCAFEF00D || hi !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL mtlo_result: lo=%h rdata=%h hi=%h, expected cafef00d cafef00d 12345678", lo, rdata, hi);
        end
        op = MUDI_MULT;
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rdata_other: rdata=%h, expected 00000000", rdata);
        end
    endtask

    task automatic test_flush();
        op = MUDI_MULT; a = 32'h00000003; b = 32'h00000004; start = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stall: stall=%b, expected 0", stall);
        end
        tick();
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL flush_result: busy=%b hi=%h lo=%h, expected 0 12345678 cafef00d", busy, hi, lo);
        end
        op = MUDI_MTHI; a = 32'hDEADBEEF; we = 1'b1; flush = 1'b1;
        tick();
        we = 1'b0; flush = 1'b0;
        checks++;
        if (hi !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL flush_we: hi=%h, expected 12345678", hi);
        end
    endtask

    task automatic test_back_to_back();
        op = MUDI_MULT; a = 32'hFFFFFFFE; b = 32'hFFFFFFFD; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h00000006) begin
            errors++;
            $display("[TB] FAIL b2b_mult: busy=%b hi=%h lo=%h, expected 0 00000000 00000006", busy, hi, lo);
        end
        op = MUDI_DIV; a = 32'h00000007; b = 32'hFFFFFFFE; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_launch: busy=%b, expected 1", busy);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL b2b_div: busy=%b hi=%h lo=%h, expected 0 00000001 fffffffd", busy, hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        op = MUDI_DIVU; a = 32'h00000064; b = 32'h00000007; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_reset: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_nocommit: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_flush_inflight();
        test_div();
        test_div_zero();
        test_moves();
        test_flush();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mudi_seq.md
MUDI_SEQ -- requirements
Module: mudi_seq

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have reset, input, 1, synchronous, active-high.
REQ-003 SHALL have start, input, 1, E-stage MuDiStart; launches the op selected by op.
REQ-004 SHALL have we, input, 1, E-stage MuDiWrite; mthi/mtlo strobe.
REQ-005 SHALL have op, input, 3, MuDiOp using the `mudi_*` encodings from header.v.
REQ-006 SHALL have flush, input, 1, exception/eret flush of the E-stage instruction.
REQ-007 SHALL have a, input, 32, rs operand.
REQ-008 SHALL have b, input, 32, rt operand.
REQ-009 SHALL have busy, output, 1, an operation is in flight.
REQ-010 SHALL have stall, output, 1, combinational busy | (start & ~flush), to the hazard unit.
REQ-011 SHALL have hi, output, 32, architectural HI register.
REQ-012 SHALL have lo, output, 32, architectural LO register.
REQ-013 SHALL have rdata, output, 32, combinational: hi when op = `mudi_mfhi`; lo when op = `mudi_mflo`; else 0.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV; reset state is IDLE.
REQ-015 In IDLE, start & ~flush with op = `mudi_mult` or `mudi_multu` SHALL latch the product into a 64-bit shadow register, load count = 5, and enter MUL.
REQ-016 In IDLE, start & ~flush with op = `mudi_div` or `mudi_divu` SHALL latch quotient and remainder (or a div-by-zero flag) into the shadow register, load count = 10, and enter DIV.
REQ-017 mult and div SHALL be signed (two's complement); multu and divu SHALL be unsigned; the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-018 In MUL and DIV, count SHALL decrement by 1 each cycle; when count = 1, the shadow register SHALL commit (HI = upper/remainder, LO = lower/quotient) and the FSM SHALL return to IDLE.
REQ-019 busy SHALL be high in every cycle the FSM is not IDLE: for a start in cycle T, busy is high T+1..T+N (N = 5 mult, 10 div), and the new HI/LO are visible from T+N+1.
REQ-020 A divide with b = 0 SHALL still run the full 10 cycles and SHALL leave HI and LO unchanged.
REQ-021 In IDLE, we & ~flush SHALL write a to HI (`mudi_mthi`) or to LO (`mudi_mtlo`) at the next edge, with no busy.
REQ-022 start and we SHALL be ignored while busy; the hazard unit guarantees they are not issued then.
REQ-023 flush SHALL suppress start and we in the same cycle only; an operation already in flight SHALL complete and commit normally.
REQ-024 If start and we are both high in the same cycle, start SHALL take priority and we SHALL be ignored.
REQ-025 The commit edge SHALL allow a new start in the following IDLE cycle (back-to-back ops with no gap beyond IDLE).
REQ-026 rdata during busy SHALL return the old HI/LO; stall prevents its use.

Reset
REQ-027 On reset high at an edge: state = IDLE, count = 0, busy = 0, hi = 0, lo = 0, shadow = 0.
REQ-028 Reset during MUL or DIV SHALL abort the op with no later commit; reset SHALL take priority over start, we and commit in the same cycle.

Verification
REQ-029 mult a=0xFFFFFFFF, b=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-030 multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-031 div a=0xFFFFFFF9, b=0x00000002 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. A following divu with b=0 -> 10 busy cycles, hi/lo unchanged.
REQ-032 mthi a=0x12345678 -> hi=0x12345678 next cycle, busy stays 0. Then op=`mudi_mfhi` -> rdata=0x12345678.
REQ-033 start=1 and flush=1, op=`mudi_mult` -> busy and stall stay 0; hi/lo unchanged.
REQ-034 Reset asserted in the 3rd busy cycle of a div -> busy=0 and hi=lo=0 next cycle; no update for the following 10 cycles.
